// File: rtl/segre_ic_refill_if.sv
// Memory-side bus of the icache refill engine: one line request, then in-order word beats.
// master = refill engine, slave = memory.
interface segre_ic_refill_if #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
);
    logic                 req;
    logic [ADDR_SIZE-1:0] addr;
    logic                 gnt;
    logic                 rvalid;
    logic [WORD_SIZE-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/segre_ic_refill.sv
// Icache refill engine: latches an IF miss, fetches the lane as word beats, returns it with an LRU victim.
// Optional feature: define ICREFILL_PERF_CNT_EN to build the completed-refill counter on miss_cnt_o.
module segre_ic_refill #(
    parameter int ADDR_SIZE         = 32,
    parameter int WORD_SIZE         = 32,
    parameter int ICACHE_LANE_SIZE  = 128,
    parameter int ICACHE_NUM_LANES  = 4,
    parameter int ICACHE_INDEX_SIZE = 2,
    parameter int ICACHE_BYTE_SIZE  = 4
) (
    input  logic                         clk_i,
    input  logic                         rsn_i,
    input  logic                         ic_access_i,
    input  logic                         ic_miss_i,
    input  logic [ADDR_SIZE-1:0]         ic_addr_i,
    output logic                         mmu_data_o,
    output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
    output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
    segre_ic_refill_if.master            mem,
    output logic [31:0]                  miss_cnt_o
);

    localparam int BEATS  = ICACHE_LANE_SIZE / WORD_SIZE;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_SIZE-1:0] OFF_MASK = ADDR_SIZE'((2 ** ICACHE_BYTE_SIZE) - 1);
    localparam logic [ICACHE_INDEX_SIZE-1:0] OLDEST = ICACHE_INDEX_SIZE'(ICACHE_NUM_LANES - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, REQ, FILL, RESP, WAIT} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_SIZE-1:0]         line_q;
    logic [ICACHE_INDEX_SIZE-1:0] victim_q, victim_c;
    logic [BEAT_W-1:0]            beat_q;
    logic [ICACHE_LANE_SIZE-1:0]  lane_q, lane_nxt;
    logic [ICACHE_LANE_SIZE-1:0]  wr_data_q;
    logic [ICACHE_INDEX_SIZE-1:0] lru_idx_q;
    logic [ICACHE_INDEX_SIZE-1:0] age_q   [ICACHE_NUM_LANES];
    logic [ICACHE_INDEX_SIZE-1:0] age_nxt [ICACHE_NUM_LANES];
    logic                         miss_take, beat_take, last_beat;
    logic                         upd;
    logic [ICACHE_INDEX_SIZE-1:0] upd_k, upd_a;

    assign miss_take = (state_q == IDLE) && ic_access_i && ic_miss_i;
    assign beat_take = (state_q == FILL) && mem.rvalid;
    assign last_beat = beat_take && (beat_q == LAST_BEAT);

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem.req    = 1'b0;
        mmu_data_o = 1'b0;
        case (state_q)
            IDLE: if (miss_take) state_d = REQ;
            REQ: begin
                mem.req = 1'b1;
                if (mem.gnt) state_d = FILL;
            end
            FILL: if (last_beat) state_d = RESP;
            RESP: begin
                mmu_data_o = 1'b1;
                state_d    = WAIT;
            end
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem.addr        = line_q;
    assign mmu_wr_data_o   = wr_data_q;
    assign mmu_lru_index_o = lru_idx_q;

    // The victim is the oldest lane, sampled at the miss so later hits cannot move it.
    always_comb begin
        victim_c = '0;
        for (int i = 0; i < ICACHE_NUM_LANES; i++) begin
            if (age_q[i] == OLDEST) victim_c = ICACHE_INDEX_SIZE'(i);
        end
    end

    always_comb begin
        lane_nxt = lane_q;
        lane_nxt[beat_q*WORD_SIZE +: WORD_SIZE] = mem.rdata;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            line_q    <= '0;
            victim_q  <= '0;
            beat_q    <= '0;
            lane_q    <= '0;
            wr_data_q <= '0;
            lru_idx_q <= '0;
        end else begin
            if (miss_take) begin
                line_q   <= ic_addr_i & ~OFF_MASK;
                victim_q <= victim_c;
            end
            if (beat_take) begin
                lane_q <= lane_nxt;
                beat_q <= last_beat ? '0 : beat_q + 1'b1;
            end
            if (last_beat) begin
                wr_data_q <= lane_nxt;
                lru_idx_q <= victim_q;
            end
        end
    end

    // True-LRU: the touched lane becomes youngest, every lane younger than it ages by one.
    // A fill in RESP takes priority over a same-cycle hit.
    always_comb begin
        upd   = 1'b0;
        upd_k = '0;
        if (state_q == RESP) begin
            upd   = 1'b1;
            upd_k = victim_q;
        end else if (ic_access_i && !ic_miss_i) begin
            upd   = 1'b1;
            upd_k = ic_addr_i[ICACHE_INDEX_SIZE-1:0];
        end
        upd_a = age_q[upd_k];
        for (int j = 0; j < ICACHE_NUM_LANES; j++) begin
            age_nxt[j] = age_q[j];
            if (upd) begin
                if (ICACHE_INDEX_SIZE'(j) == upd_k) age_nxt[j] = '0;
                else if (age_q[j] < upd_a)          age_nxt[j] = age_q[j] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < ICACHE_NUM_LANES; i++) age_q[i] <= ICACHE_INDEX_SIZE'(i);
        end else begin
            for (int i = 0; i < ICACHE_NUM_LANES; i++) age_q[i] <= age_nxt[i];
        end
    end

`ifdef ICREFILL_PERF_CNT_EN
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i)                miss_cnt_q <= '0;
        else if (state_q == RESP) miss_cnt_q <= miss_cnt_q + 32'd1;
    end

    assign miss_cnt_o = miss_cnt_q;
`else
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_segre_ic_refill.sv
// Directed bench for segre_ic_refill: expected lanes/victims queued at issue, checked by a monitor on mmu_data_o.
module tb_segre_ic_refill;

    logic         clk_i = 1'b0;
    logic         rsn_i = 1'b0;
    logic         ic_access_i = 1'b0;
    logic         ic_miss_i = 1'b0;
    logic [31:0]  ic_addr_i = '0;
    logic         mmu_data_o;
    logic [127:0] mmu_wr_data_o;
    logic [1:0]   mmu_lru_index_o;
    logic [31:0]  miss_cnt_o;

    int tests = 0;
    int fails = 0;
    logic [129:0] exp_q[$];

    segre_ic_refill_if #(.ADDR_SIZE(32), .WORD_SIZE(32)) mem_if ();

    segre_ic_refill dut (
        .clk_i           (clk_i),
        .rsn_i           (rsn_i),
        .ic_access_i     (ic_access_i),
        .ic_miss_i       (ic_miss_i),
        .ic_addr_i       (ic_addr_i),
        .mmu_data_o      (mmu_data_o),
        .mmu_wr_data_o   (mmu_wr_data_o),
        .mmu_lru_index_o (mmu_lru_index_o),
        .mem             (mem_if),
        .miss_cnt_o      (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every refill-complete pulse must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (rsn_i && mmu_data_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got mmu_data_o=1 expected none");
            end else begin
                logic [129:0] e;
                e = exp_q.pop_front();
                chk("resp_lane", mmu_wr_data_o, e[127:0]);
                chk("resp_index", {126'd0, mmu_lru_index_o}, {126'd0, e[129:128]});
            end
        end
    end

    task automatic hit(input logic [1:0] k);
        @(posedge clk_i) #1;
        ic_access_i = 1'b1; ic_miss_i = 1'b0; ic_addr_i = {30'd0, k};
        @(posedge clk_i) #1;
        ic_access_i = 1'b0; ic_addr_i = '0;
    endtask

    // Full refill; hit_fill/hit_resp >= 0 inject a hit at beat 1 / in the RESP cycle,
    // extra_miss drives a second miss together with beat 2.
    task automatic refill(input logic [31:0] addr, input logic [127:0] lane, input int gap,
                          input logic [1:0] exp_idx, input int hit_fill, input int hit_resp,
                          input bit extra_miss);
        logic [31:0] line;
        line = addr & 32'hFFFF_FFF0;
        exp_q.push_back({exp_idx, lane});
        @(posedge clk_i) #1;
        ic_access_i = 1'b1; ic_miss_i = 1'b1; ic_addr_i = addr;
        @(posedge clk_i) #1;
        ic_access_i = 1'b0; ic_miss_i = 1'b0; ic_addr_i = '0;
        chk("req_asserted", {127'd0, mem_if.req}, 128'd1);
        chk("req_addr", {96'd0, mem_if.addr}, {96'd0, line});
        mem_if.rvalid = 1'b1; mem_if.rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk_i) #1;
            mem_if.rvalid = 1'b0;
            chk("req_held", {127'd0, mem_if.req}, 128'd1);
            chk("addr_held", {96'd0, mem_if.addr}, {96'd0, line});
        end
        mem_if.gnt = 1'b1;
        @(posedge clk_i) #1;
        mem_if.gnt = 1'b0;
        chk("req_dropped", {127'd0, mem_if.req}, 128'd0);
        for (int b = 0; b < 4; b++) begin
            repeat (gap) @(posedge clk_i) #1;
            mem_if.rvalid = 1'b1; mem_if.rdata = lane[b*32 +: 32];
            if (b == 1 && hit_fill >= 0) begin
                ic_access_i = 1'b1; ic_miss_i = 1'b0; ic_addr_i = hit_fill;
            end
            if (b == 2 && extra_miss) begin
                ic_access_i = 1'b1; ic_miss_i = 1'b1; ic_addr_i = 32'h0000_5554;
            end
            @(posedge clk_i) #1;
            mem_if.rvalid = 1'b0;
            ic_access_i = 1'b0; ic_miss_i = 1'b0; ic_addr_i = '0;
        end
        if (hit_resp >= 0) begin
            ic_access_i = 1'b1; ic_miss_i = 1'b0; ic_addr_i = hit_resp;
        end
        @(posedge clk_i) #1;
        ic_access_i = 1'b0; ic_addr_i = '0;
        @(posedge clk_i) #1;
        chk("idle_no_req", {127'd0, mem_if.req}, 128'd0);
        chk("pulse_low", {127'd0, mmu_data_o}, 128'd0);
        chk("lane_held", mmu_wr_data_o, lane);
    endtask

    task automatic do_reset();
        @(posedge clk_i) #1;
        rsn_i = 1'b0;
        repeat (2) @(posedge clk_i) #1;
        rsn_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = '0;
        repeat (2) @(posedge clk_i) #1;
        chk("rst_req", {127'd0, mem_if.req}, 128'd0);
        chk("rst_addr", {96'd0, mem_if.addr}, 128'd0);
        chk("rst_pulse", {127'd0, mmu_data_o}, 128'd0);
        chk("rst_lane", mmu_wr_data_o, 128'd0);
        chk("rst_index", {126'd0, mmu_lru_index_o}, 128'd0);
        chk("rst_cnt", {96'd0, miss_cnt_o}, 128'd0);
        rsn_i = 1'b1;

        // ages [0,1,2,3] -> victim 3
        refill(32'h0000_1234, 128'h00000044_00000033_00000022_00000011, 0, 2'd3, -1, -1, 1'b0);

        do_reset();
        hit(2'd3);                                              // ages [1,2,3,0]
        refill(32'h0000_2008, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 3, 2'd2, -1, -1, 1'b1);
        // ages [2,3,0,1]; hit on lane 0 during fill -> [0,3,1,2]; fill lane 1 -> [1,0,2,3]
        refill(32'h0000_0040, 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1, 1, 2'd1, 0, -1, 1'b0);
        // fill lane 3 wins over the RESP-cycle hit on lane 0 -> [2,1,3,0]
        refill(32'h8000_00FC, 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1, 0, 2'd3, -1, 0, 1'b0);
`ifdef ICREFILL_PERF_CNT_EN
        chk("miss_cnt", {96'd0, miss_cnt_o}, 128'd3);
`else
        chk("miss_cnt", {96'd0, miss_cnt_o}, 128'd0);
`endif
        refill(32'h0000_3000, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 0, 2'd2, -1, -1, 1'b0);

        // Abort during beat 2 of a refill
        @(posedge clk_i) #1;
        ic_access_i = 1'b1; ic_miss_i = 1'b1; ic_addr_i = 32'h0000_4000;
        @(posedge clk_i) #1;
        ic_access_i = 1'b0; ic_miss_i = 1'b0; ic_addr_i = '0;
        mem_if.gnt = 1'b1;
        @(posedge clk_i) #1;
        mem_if.gnt = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_if.rvalid = 1'b1; mem_if.rdata = 32'hE0E0_E000 + b;
            @(posedge clk_i) #1;
        end
        mem_if.rdata = 32'hE0E0_E002;
        #2 rsn_i = 1'b0;
        #1;
        chk("abort_lane", mmu_wr_data_o, 128'd0);
        chk("abort_index", {126'd0, mmu_lru_index_o}, 128'd0);
        chk("abort_addr", {96'd0, mem_if.addr}, 128'd0);
        chk("abort_cnt", {96'd0, miss_cnt_o}, 128'd0);
        mem_if.rvalid = 1'b0;
        repeat (2) @(posedge clk_i) #1;
        rsn_i = 1'b1;
        refill(32'h0000_5010, 128'hF4F4F4F4_F3F3F3F3_F2F2F2F2_F1F1F1F1, 2, 2'd3, -1, -1, 1'b0);

        repeat (3) @(posedge clk_i) #1;
        chk("all_responses_seen", {96'd0, 32'(exp_q.size())}, 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
